// File: rtl/cv32e40x_prefetch_ctrl_mo.sv
// Multi-outstanding prefetch controller for the IF stage.
// Issues word-aligned fetch requests (sequential and branch targets) to the
// OBI adapter, limits in-flight requests with a credit check so the fetch
// FIFO can never overflow, and drops responses that belong to requests
// issued before a taken branch.
// Optional build macro: CV32E40X_PREFETCH_PAGE_GUARD_EN. When it is defined,
// sequential prefetch stops at a page boundary until the pipeline has drained.
module cv32e40x_prefetch_ctrl_mo #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned PAGE_BITS       = 12,
    localparam int unsigned CNT_W          = $clog2(DEPTH + 1),
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic [CNT_W-1:0]  fifo_cnt_i,
    output logic              trans_valid_o,
    input  logic              trans_ready_i,
    output logic [ADDR_W-1:0] trans_addr_o,
    input  logic              resp_valid_i,
    output logic              fetch_valid_o,
    output logic [OUT_W-1:0]  outstanding_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        BRANCH_WAIT = 2'd1
`ifdef CV32E40X_PREFETCH_PAGE_GUARD_EN
        ,
        PAGE_WAIT   = 2'd2
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] trans_addr_q, trans_addr_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [OUT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] seq_addr;
    logic [CNT_W-1:0]  fifo_eff;
    logic [31:0]       words_in_use;
    logic              credit_ok;
    logic              page_cross;
    logic              want;
    logic              transfer;

    // Request generation, credit check and next-state computation.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        branch_tgt = branch_addr_i & ~ADDR_W'(3);
        seq_addr   = trans_addr_q + ADDR_W'(4);

        if (branch_i) begin
            trans_addr_o = branch_tgt;
        end else if (state_q == BRANCH_WAIT) begin
            trans_addr_o = trans_addr_q;
        end else begin
            trans_addr_o = seq_addr;
        end

        // The FIFO is being cleared by a redirect, so its occupancy does not count.
        fifo_eff     = (branch_i || state_q == BRANCH_WAIT) ? '0 : fifo_cnt_i;
        // Live (non-flushed) requests plus words already buffered.
        words_in_use = 32'(outstanding_q) - 32'(flush_cnt_q) + 32'(fifo_eff);
        credit_ok    = (32'(outstanding_q) < MAX_OUTSTANDING) && (words_in_use < DEPTH);

        page_cross = 1'b0;
`ifdef CV32E40X_PREFETCH_PAGE_GUARD_EN
        page_cross = (state_q == IDLE) && !branch_i && req_i &&
                     (seq_addr[PAGE_BITS-1:2] == '0);
`endif

        want = branch_i || (state_q == BRANCH_WAIT) ||
               (req_i && (state_q == IDLE) && !page_cross);
`ifdef CV32E40X_PREFETCH_PAGE_GUARD_EN
        // The crossing address waits for an empty pipeline and an empty FIFO.
        if (state_q == PAGE_WAIT && !branch_i) begin
            want = req_i && (outstanding_q == '0) && (fifo_cnt_i == '0);
        end
`endif

        trans_valid_o = !rst && credit_ok && want;
        transfer      = trans_valid_o && trans_ready_i;

        state_d = state_q;
        if (branch_i) begin
            state_d = transfer ? IDLE : BRANCH_WAIT;
        end else if (transfer) begin
            state_d = IDLE;
`ifdef CV32E40X_PREFETCH_PAGE_GUARD_EN
        end else if (page_cross) begin
            state_d = PAGE_WAIT;
`endif
        end

        trans_addr_d  = (branch_i || transfer) ? trans_addr_o : trans_addr_q;
        outstanding_d = outstanding_q + OUT_W'(transfer) - OUT_W'(resp_valid_i);

        // Everything in flight at a branch is stale, except a target issued in that same cycle.
        if (branch_i) begin
            flush_cnt_d = outstanding_q - OUT_W'(resp_valid_i);
        end else if (resp_valid_i && flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - OUT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end

        fetch_valid_o = resp_valid_i && (flush_cnt_q == '0) && !branch_i;
        outstanding_o = outstanding_q;
        busy_o        = (outstanding_q != '0) || (state_q != IDLE);
    end

    // State, address and counter registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            trans_addr_q  <= '0;
            outstanding_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            trans_addr_q  <= trans_addr_d;
            outstanding_q <= outstanding_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk)
        (PAGE_BITS + 1 <= ADDR_W) && (MAX_OUTSTANDING <= DEPTH) && (MAX_OUTSTANDING >= 1));

    a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        resp_valid_i |-> (outstanding_q != '0));

    a_fifo_cnt_range: assert property (@(posedge clk) disable iff (rst)
        32'(fifo_cnt_i) <= DEPTH);

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        fetch_valid_o |-> (32'(fifo_cnt_i) < DEPTH));

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (trans_valid_o && !trans_ready_i) |=> (branch_i || $stable(trans_addr_o)));
`endif

endmodule

// File: doc/cv32e40x_prefetch_ctrl_mo.md
Name: cv32e40x_prefetch_ctrl_mo

Overview:
Multi-outstanding prefetch controller in the IF stage, between the fetch FIFO and the OBI instruction bus interface adapter. It generates word-aligned transaction requests, both sequential and on taken branches. It throttles requests using credits so that the fetch FIFO can never overflow, with up to MAX_OUTSTANDING transactions in flight. Responses to transactions issued before a taken branch are discarded internally. The IF stage never sees stale instructions.

Parameters:
ADDR_W, 32, transaction/branch address width (>=PAGE_BITS+1).
DEPTH, 2, fetch FIFO depth in words (>=1).
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..DEPTH).
PAGE_BITS, 12, log2 of the page size used by the optional page guard.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_i  input  1  IF stage wants instructions; sequential prefetch enabled
branch_i  input  1  taken branch/flush this cycle; the IF stage clears the FIFO in the same cycle
branch_addr_i  input  ADDR_W  branch target (valid with branch_i)
fifo_cnt_i  input  $clog2(DEPTH+1)  current fetch FIFO occupancy
trans_valid_o  output  1  transaction request to the adapter
trans_ready_i  input  1  adapter accepts (transfer = valid && ready)
trans_addr_o  output  ADDR_W  transaction address, bits [1:0] always 0
resp_valid_i  input  1  response from the adapter; always consumed
fetch_valid_o  output  1  response is valid for the FIFO (not flushed)
outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
busy_o  output  1  outstanding_o != 0 or state != IDLE

Behaviour:
- Reset values: state IDLE, trans_addr_q=0, outstanding_q=0, flush_cnt_q=0, so outstanding_o=0, fetch_valid_o=0, busy_o=0. trans_valid_o is forced to 0 while rst=1. Reset mid-transaction drops all counts; any later responses are a protocol error.
- States:
  - IDLE: sequential prefetch.
  - BRANCH_WAIT: branch target is pending acceptance.
  - PAGE_WAIT: only when the optional feature is compiled in.
- Address selection:
  - branch_i=1: trans_addr_o = {branch_addr_i[ADDR_W-1:2],2'b00} in any state.
  - BRANCH_WAIT without branch_i: trans_addr_o = trans_addr_q.
  - Otherwise: trans_addr_o = trans_addr_q + 4, wrapping modulo 2^ADDR_W.
  - trans_addr_q loads trans_addr_o when branch_i or on a transfer.
- Credit:
  - credit_ok = (outstanding_q < MAX_OUTSTANDING) && (outstanding_q - flush_cnt_q + fifo_eff < DEPTH).
  - fifo_eff = 0 when branch_i is asserted or the state is BRANCH_WAIT; otherwise fifo_eff = fifo_cnt_i.
- trans_valid_o = !rst && credit_ok && (branch_i || state==BRANCH_WAIT || (req_i && state==IDLE)). It has no combinational path from resp_valid_i.
- Transitions:
  - IDLE -> BRANCH_WAIT on branch_i without a transfer.
  - BRANCH_WAIT -> IDLE on a transfer.
  - A new branch_i while in BRANCH_WAIT replaces the pending target.
- outstanding_q next = outstanding_q + transfer - resp_valid_i. Simultaneous transfer and response leaves it unchanged.
- Flush count update:
  - On branch_i: flush_cnt_q <= outstanding_q - resp_valid_i. A transfer in the branch cycle is the target and is not flushed.
  - Otherwise: flush_cnt_q decrements on resp_valid_i while it is nonzero.
- fetch_valid_o = resp_valid_i && flush_cnt_q==0 && !branch_i. A response in the branch cycle is dropped.
- Assertions (SVA, simulation only):
  - resp_valid_i with outstanding_q==0 never occurs.
  - fifo_cnt_i <= DEPTH.
  - Accepted responses never cause FIFO overflow.
  - trans_addr_o is stable while trans_valid_o && !trans_ready_i, unless branch_i.

Optional Feature:
CV32E40X_PREFETCH_PAGE_GUARD_EN.
- Defined:
  - In IDLE, a sequential request whose address has bits [PAGE_BITS-1:2] all zero (a page crossing) is not issued. The state moves to PAGE_WAIT.
  - PAGE_WAIT holds trans_valid_o=0 until outstanding_q==0 and fifo_cnt_i==0, then returns to IDLE and issues the crossing address.
  - branch_i in PAGE_WAIT behaves as in IDLE.
  - Branch targets are never guarded.
- Undefined: no PAGE_WAIT state, and sequential prefetch crosses pages freely.

Test Plan:
- Reset with req_i=1 and branch_i=1 to 0x100 (DEPTH=2, MAX_OUTSTANDING=2, ready=1): transfers at 0x100 and 0x104, then trans_valid_o=0 with outstanding_o=2 until resp_valid_i.
- branch_i to 0x203 with trans_ready_i=0 for 3 cycles: trans_addr_o=0x200 held in BRANCH_WAIT; transfer on the 4th cycle; state returns to IDLE; next sequential address 0x204.
- 2 outstanding, then branch to 0x400 accepted the same cycle: the next 2 responses give fetch_valid_o=0, the 3rd gives fetch_valid_o=1; outstanding_o sequence is 3,2,1,0 (with MAX_OUTSTANDING=3).
- fifo_cnt_i=2, DEPTH=2, outstanding 0: trans_valid_o=0. fifo_cnt_i drops to 1: trans_valid_o=1.
- Sequential address 0xFFFFFFFC: the next request is at 0x00000000 (wrap) with no error.
- With PAGE_GUARD_EN: prefetch 0xFF8, 0xFFC, then 0x1000 is held until outstanding=0 and fifo_cnt_i=0. Without the macro, 0x1000 issues immediately when credit allows.
